vga_frame_capture: RTL

//  Synthesizable sink for the VGA pixel stream produced by the system's display path.
//  - Samples h_sync/v_sync/rgb on each pixel-clock enable.
//  - Recovers raster position from the sync edges.
//  - Writes one armed frame of active pixels into a frame-buffer RAM write port.
//  - Placed beside the display controller for on-chip self-check of rendered output.

---
 rtl/vga_frame_capture.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: recovers raster position from VGA syncs and writes one armed frame of active pixels.
// Define CAPTURE_CRC_EN to add output crc, a CRC-16-CCITT over every written pixel.
module vga_frame_capture #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIX_W    = 8,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_en,
   input  logic              h_sync,
   input  logic              v_sync,
   input  logic [PIX_W-1:0]  rgb,
   input  logic              arm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              frame_err
`ifdef CAPTURE_CRC_EN
   ,
   output logic [15:0]       crc
`endif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL) + 1;
   localparam int VW = $clog2(V_TOTAL) + 1;
   localparam logic [HW-1:0] H_LO = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_HI = HW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LO = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_HI = VW'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
   state_t state, state_n;
   logic hs_q, vs_q, h_fall, v_fall, active, last, err, wr, arm_go;
   logic [HW-1:0] h_cnt, h_nxt;
   logic [VW-1:0] v_cnt, v_nxt;
   logic [ADDR_W-1:0] wcnt;

`ifdef CAPTURE_CRC_EN
   localparam int DW = PIX_W < 8 ? 8 : PIX_W;
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [DW-1:0] d);
      logic [15:0] r;
      r = c;
      for (int i = DW - 1; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction
`endif

   // Position of the pixel being sampled right now; a v edge overrides the h-edge line increment.
   always_comb begin
      h_fall = pix_en && hs_q && !h_sync;
      v_fall = pix_en && vs_q && !v_sync;
      h_nxt  = h_fall ? '0 : h_cnt + HW'(1);
      v_nxt  = v_fall ? '0 : h_fall ? v_cnt + VW'(1) : v_cnt;
      active = h_nxt >= H_LO && h_nxt < H_HI && v_nxt >= V_LO && v_nxt < V_HI;
      last   = mem_we && mem_addr == LAST;
      err    = state == CAPTURE && !last && ((h_fall && h_cnt != H_END) || v_fall);
      wr     = state == CAPTURE && pix_en && active && !last && !err;
      arm_go = state == IDLE && arm;
   end

   always_comb begin
      state_n = state;
      busy    = state == ARMED || state == CAPTURE;
      done    = state == DONE;
      unique case (state)
         IDLE:    state_n = arm ? ARMED : IDLE;
         ARMED:   state_n = v_fall ? CAPTURE : ARMED;
         CAPTURE: state_n = last ? DONE : err ? IDLE : CAPTURE;
         DONE:    state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         h_cnt     <= '0;
         v_cnt     <= '0;
         wcnt      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         frame_err <= 1'b0;
`ifdef CAPTURE_CRC_EN
         crc       <= '0;
`endif
      end else begin
         if (pix_en) begin
            hs_q  <= h_sync;
            vs_q  <= v_sync;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
         end
         mem_we <= wr;
         if (wr) begin
            mem_addr  <= wcnt;
            mem_wdata <= rgb;
            wcnt      <= wcnt + ADDR_W'(1);
         end
         if (arm_go) wcnt <= '0;
         frame_err <= arm_go ? 1'b0 : frame_err || err;
`ifdef CAPTURE_CRC_EN
         if (arm_go) crc <= 16'hFFFF;
         else if (wr) crc <= crc_upd(crc, DW'(rgb));
`endif
      end
   end
endmodule
